// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-unit definitions: FSM state encodings and the reset instruction.
package instr_fetch_unit_pkg;

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/instr_fetch_unit_next_pc_gen.sv
// Combinational next-PC selection for the fetch unit: jalr > jump > branch > sequential.
module instr_fetch_unit_next_pc_gen
  import instr_fetch_unit_pkg::*;
(
  input  logic [31:0] i_instr_pc,
  input  logic [31:0] i_imm_ext,
  input  logic [31:0] i_alu_result,
  input  logic        i_branch_taken,
  input  logic        i_jump,
  input  logic        i_jalr,
  output logic [31:0] o_next_pc,
  output logic        o_misaligned
);

  logic [31:0] w_rel_target;
  logic [31:0] w_seq_target;

  assign w_rel_target = i_instr_pc + i_imm_ext;
  assign w_seq_target = i_instr_pc + 32'd4;

  always_comb begin
    o_next_pc = w_seq_target;
    if (i_jalr) begin
      o_next_pc = {i_alu_result[31:1], 1'b0};
    end else if (i_jump || i_branch_taken) begin
      o_next_pc = w_rel_target;
    end
  end

  // jalr only clears bit 0, so bit 1 can still leave the target off a word boundary
  assign o_misaligned = (o_next_pc[1:0] != 2'b00);

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32I fetch front end: owns the PC, fetches one word at a time, holds it for decode.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  output logic             o_imem_req,
  output logic [31:0]      o_imem_addr,
  input  logic             i_imem_gnt,
  input  logic             i_imem_rvalid,
  input  logic [31:0]      i_imem_rdata,
  output logic [31:0]      o_instr,
  output logic [31:0]      o_instr_pc,
  output logic [31:0]      o_instr_pcplus4,
  output logic             o_instr_valid,
  input  logic             i_instr_ready,
  input  logic             i_branch_taken,
  input  logic             i_jump,
  input  logic             i_jalr,
  input  logic [31:0]      i_imm_ext,
  input  logic [31:0]      i_alu_result,
  output logic             o_misalign_err,
  output logic [CNT_W-1:0] o_retired_cnt
);

  logic [1:0]       r_state;
  logic [31:0]      r_pc;
  logic [31:0]      r_instr;
  logic [31:0]      r_instr_pc;
  logic [CNT_W-1:0] r_retired_cnt;

  logic [31:0]      w_next_pc;
  logic             w_misaligned;

  instr_fetch_unit_next_pc_gen u_next_pc_gen (
    .i_instr_pc     (r_instr_pc),
    .i_imm_ext      (i_imm_ext),
    .i_alu_result   (i_alu_result),
    .i_branch_taken (i_branch_taken),
    .i_jump         (i_jump),
    .i_jalr         (i_jalr),
    .o_next_pc      (w_next_pc),
    .o_misaligned   (w_misaligned)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_REQ;
      r_pc          <= RESET_PC;
      r_instr       <= NOP_INSTR;
      r_instr_pc    <= RESET_PC;
      r_retired_cnt <= '0;
    end else begin
      case (r_state)
        S_REQ: begin
          if (i_imem_gnt) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_imem_rvalid) begin
            r_instr    <= i_imem_rdata;
            r_instr_pc <= r_pc;
            r_state    <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (i_instr_ready) begin
            r_pc          <= w_next_pc;
            r_retired_cnt <= r_retired_cnt + CNT_W'(1);
            r_state       <= w_misaligned ? S_ERR : S_REQ;
          end
        end
        default: begin
          r_state <= S_ERR;
        end
      endcase
    end
  end

  // Gating with reset keeps req low while held in reset yet high on the first free cycle
  assign o_imem_req      = (r_state == S_REQ) && !i_reset;
  assign o_imem_addr     = r_pc;
  assign o_instr         = r_instr;
  assign o_instr_pc      = r_instr_pc;
  assign o_instr_pcplus4 = r_instr_pc + 32'd4;
  assign o_instr_valid   = (r_state == S_HOLD);
  assign o_misalign_err  = (r_state == S_ERR);
  assign o_retired_cnt   = r_retired_cnt;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit.
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pcplus4;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_taken;
  logic        jump;
  logic        jalr;
  logic [31:0] imm_ext;
  logic [31:0] alu_result;
  logic        misalign_err;
  logic [31:0] retired_cnt;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .CNT_W    (32)
  ) dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .o_imem_req      (imem_req),
    .o_imem_addr     (imem_addr),
    .i_imem_gnt      (imem_gnt),
    .i_imem_rvalid   (imem_rvalid),
    .i_imem_rdata    (imem_rdata),
    .o_instr         (instr),
    .o_instr_pc      (instr_pc),
    .o_instr_pcplus4 (instr_pcplus4),
    .o_instr_valid   (instr_valid),
    .i_instr_ready   (instr_ready),
    .i_branch_taken  (branch_taken),
    .i_jump          (jump),
    .i_jalr          (jalr),
    .i_imm_ext       (imm_ext),
    .i_alu_result    (alu_result),
    .o_misalign_err  (misalign_err),
    .o_retired_cnt   (retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values();
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_err", {31'd0, misalign_err}, 32'd0);
    check("rst_cnt", retired_cnt, 32'd0);
  endtask

  // Starts in the request state; gdly idle cycles before gnt, rvalid rdly cycles after gnt.
  task automatic fetch(input logic [31:0] pc, input int gdly, input int rdly,
                       input logic [31:0] data);
    check("req_addr", imem_addr, pc);
    check("req_on", {31'd0, imem_req}, 32'd1);
    for (int i = 0; i < gdly; i++) begin
      tick();
      check("addr_held", imem_addr, pc);
      check("req_held", {31'd0, imem_req}, 32'd1);
    end
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    check("req_drop", {31'd0, imem_req}, 32'd0);
    check("wait_valid", {31'd0, instr_valid}, 32'd0);
    for (int i = 1; i < rdly; i++) begin
      tick();
      check("wait_valid", {31'd0, instr_valid}, 32'd0);
      check("wait_req", {31'd0, imem_req}, 32'd0);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
    check("hold_valid", {31'd0, instr_valid}, 32'd1);
    check("hold_instr", instr, data);
    check("hold_pc", instr_pc, pc);
    check("hold_pcplus4", instr_pcplus4, pc + 32'd4);
  endtask

  task automatic retire(input logic br, input logic jmp, input logic jr,
                        input logic [31:0] imm, input logic [31:0] alu);
    branch_taken = br;
    jump         = jmp;
    jalr         = jr;
    imm_ext      = imm;
    alu_result   = alu;
    instr_ready  = 1'b1;
    tick();
    instr_ready  = 1'b0;
    branch_taken = 1'b0;
    jump         = 1'b0;
    jalr         = 1'b0;
    imm_ext      = 32'h0;
    alu_result   = 32'h0;
    check("retire_valid", {31'd0, instr_valid}, 32'd0);
  endtask

  initial begin
    reset        = 1'b1;
    imem_gnt     = 1'b0;
    imem_rvalid  = 1'b0;
    imem_rdata   = 32'h0;
    instr_ready  = 1'b0;
    branch_taken = 1'b0;
    jump         = 1'b0;
    jalr         = 1'b0;
    imm_ext      = 32'h0;
    alu_result   = 32'h0;
    tick();
    tick();
    check_reset_values();
    reset = 1'b0;
    #1;
    check("post_rst_req", {31'd0, imem_req}, 32'd1);

    // Sequential fetch, 1-cycle memory, consumed immediately
    fetch(32'h0, 0, 1, 32'h0010_0093);
    retire(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("cnt_1", retired_cnt, 32'd1);
    fetch(32'h4, 0, 1, 32'h0020_0113);
    retire(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    fetch(32'h8, 0, 1, 32'h0030_0193);
    retire(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("cnt_3", retired_cnt, 32'd3);
    check("seq_addr", imem_addr, 32'hC);

    // Stall: ready low, stray gnt/rvalid/redirects must not disturb the held instruction
    fetch(32'hC, 0, 1, 32'h0040_0213);
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0BAD_0BAD;
    jump        = 1'b1;
    imm_ext     = 32'h40;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_instr", instr, 32'h0040_0213);
      check("stall_pc", instr_pc, 32'hC);
      check("stall_req", {31'd0, imem_req}, 32'd0);
      check("stall_valid", {31'd0, instr_valid}, 32'd1);
      check("stall_cnt", retired_cnt, 32'd3);
    end
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    jump        = 1'b0;

    // Redirects: 0xC+0xF4=0x100, 0x100-0x10=0xF0, 0xF0+0x10=0x100, 0x100+0x20=0x120
    retire(1'b0, 1'b1, 1'b0, 32'h0000_00F4, 32'h0);
    check("jump_to_100", imem_addr, 32'h100);
    fetch(32'h100, 0, 1, 32'hFE00_08E3);
    retire(1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0);
    check("branch_back", imem_addr, 32'hF0);
    fetch(32'hF0, 0, 1, 32'h0100_006F);
    retire(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    fetch(32'h100, 0, 1, 32'h0200_006F);
    retire(1'b0, 1'b1, 1'b0, 32'h20, 32'h0);
    check("jump_120", imem_addr, 32'h120);
    check("cnt_7", retired_cnt, 32'd7);

    // jalr wins over jump; bit 0 of the target is cleared
    fetch(32'h120, 0, 1, 32'h0000_80E7);
    retire(1'b1, 1'b1, 1'b1, 32'h40, 32'h0000_3001);
    check("jalr_prio", imem_addr, 32'h3000);

    // ready while nothing is valid is ignored
    instr_ready = 1'b1;
    jump        = 1'b1;
    imm_ext     = 32'h80;
    tick();
    instr_ready = 1'b0;
    jump        = 1'b0;
    imm_ext     = 32'h0;
    check("idle_ready_addr", imem_addr, 32'h3000);
    check("idle_ready_cnt", retired_cnt, 32'd8);

    // Slow memory: gnt after 3 cycles, rvalid 4 cycles after gnt
    fetch(32'h3000, 3, 4, 32'h0050_0293);
    retire(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("slow_next", imem_addr, 32'h3004);
    check("cnt_9", retired_cnt, 32'd9);

    // Misaligned jalr target 0x2002 traps in the error state
    fetch(32'h3004, 0, 1, 32'h0000_8067);
    retire(1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_2003);
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("err_flag", {31'd0, misalign_err}, 32'd1);
      check("err_req", {31'd0, imem_req}, 32'd0);
      check("err_valid", {31'd0, instr_valid}, 32'd0);
      tick();
    end
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;

    // Reset leaves the error state
    reset = 1'b1;
    tick();
    check_reset_values();
    reset = 1'b0;
    #1;
    check("err_exit_req", {31'd0, imem_req}, 32'd1);

    // Reset while waiting for rvalid
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    check("mid_wait_req", {31'd0, imem_req}, 32'd0);
    reset = 1'b1;
    tick();
    check_reset_values();
    reset = 1'b0;
    #1;
    check("mid_rst_req", {31'd0, imem_req}, 32'd1);
    check("mid_rst_addr", imem_addr, 32'h0);
    // rvalid arriving in the request state is ignored
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1234_5678;
    tick();
    imem_rvalid = 1'b0;
    check("stray_rvalid_valid", {31'd0, instr_valid}, 32'd0);
    check("stray_rvalid_instr", instr, 32'h0000_0013);
    fetch(32'h0, 0, 1, 32'h0060_0313);
    retire(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("after_rst_cnt", retired_cnt, 32'd1);
    check("after_rst_addr", imem_addr, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
